// File: rtl/bus_output_port_if.sv
// rtl/bus_output_port_if.sv - bus capture and valid/ready output handshake bundle for bus_output_port
interface bus_output_port_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  load_out;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Control logic / consumer side
  modport master (
    output load_out,
    output bus_in,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  // Output port side
  modport slave (
    input  load_out,
    input  bus_in,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/bus_output_port.sv
// rtl/bus_output_port.sv - bus capture FIFO with valid/ready output, latched word and sticky overflow (option: OUTPORT_DROP_OLDEST_EN)
module bus_output_port #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_output_port_if.slave      port,
  input  logic                  clear_overflow,
  output logic [DATA_WIDTH-1:0] out_latched,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  rd_en;
  logic                  wr_en;
  logic                  rd_adv;
  logic                  ovf_hit;

  // Status flags come straight from the registered occupancy count.
  assign full           = (count == CNT_FULL);
  assign empty          = (count == '0);
  assign port.out_valid = !empty;
  assign port.out_data  = empty ? '0 : mem[rd_ptr];

  // Decode this cycle's write, read and overflow events.
  always_comb begin
    rd_en   = port.out_valid && port.out_ready;
    ovf_hit = port.load_out && full && !rd_en;
`ifdef OUTPORT_DROP_OLDEST_EN
    // The new word always lands; on overflow the oldest is pushed out.
    wr_en   = port.load_out;
    rd_adv  = rd_en || ovf_hit;
`else
    // On overflow the new word is discarded.
    wr_en   = port.load_out && !ovf_hit;
    rd_adv  = rd_en;
`endif
  end

  // Storage and write pointer; last accepted word mirrored on out_latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      out_latched <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= port.bus_in;
      wr_ptr      <= wr_ptr + PTR_ONE;
      out_latched <= port.bus_in;
    end
  end

  // Read pointer advances on a consumer handshake or an oldest-word eviction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (rd_adv) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: a simultaneous push and pop (including eviction) leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_en && !rd_adv) begin
      count <= count + CNT_ONE;
    end else if (rd_adv && !wr_en) begin
      count <= count - CNT_ONE;
    end
  end

  // Sticky overflow; a new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_hit) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_output_port.sv
// tb/tb_bus_output_port.sv - randomized and directed bench for bus_output_port against a queue model
module tb_bus_output_port;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_overflow;
  logic [DW-1:0] out_latched;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_latched;
  logic          m_ovf;

  always #5 clk = ~clk;

  bus_output_port_if #(.DATA_WIDTH(DW)) bus ();

  bus_output_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .port           (bus),
    .clear_overflow (clear_overflow),
    .out_latched    (out_latched),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_latched = '0;
    m_ovf     = 1'b0;
  endtask

  // One clock of FIFO behaviour at the queue level.
  task automatic model_step(input logic ld, input logic [DW-1:0] d, input logic rdy, input logic clr);
    bit was_full;
    bit rd;
    bit hit;
    was_full = (q.size() == DEPTH);
    rd       = (q.size() != 0) && rdy;
    hit      = ld && was_full && !rd;
    if (rd) void'(q.pop_front());
    if (ld) begin
      if (!hit) begin
        q.push_back(d);
        m_latched = d;
      end else begin
`ifdef OUTPORT_DROP_OLDEST_EN
        void'(q.pop_front());
        q.push_back(d);
        m_latched = d;
`endif
      end
    end
    if (hit) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : '0;
    check_eq({tag, ".valid"},   bus.out_valid, q.size() != 0);
    check_eq({tag, ".data"},    bus.out_data,  exp_data);
    check_eq({tag, ".count"},   count,         q.size());
    check_eq({tag, ".full"},    full,          q.size() == DEPTH);
    check_eq({tag, ".empty"},   empty,         q.size() == 0);
    check_eq({tag, ".latched"}, out_latched,   m_latched);
    check_eq({tag, ".ovf"},     overflow,      m_ovf);
  endtask

  // Drive one cycle of inputs, clock, advance model, then compare.
  task automatic cycle(input string tag, input logic ld, input logic [DW-1:0] d,
                       input logic rdy, input logic clr);
    bus.load_out   = ld;
    bus.bus_in     = d;
    bus.out_ready  = rdy;
    clear_overflow = clr;
    @(posedge clk);
    model_step(ld, d, rdy, clr);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [DW-1:0] fill[4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    reset          = 1'b1;
    bus.load_out   = 1'b0;
    bus.bus_in     = '0;
    bus.out_ready  = 1'b0;
    clear_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, '0, 1'b0, 1'b0);

    // 2: single word, one-cycle latency, then consume
    cycle("t2_load", 1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("t2_data_a5", bus.out_data, 8'hA5);
    cycle("t2_read", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t2_empty", empty, 1'b1);

    // 3: fill, then overflow with 55
    for (int i = 0; i < 4; i++) cycle("t3_fill", 1'b1, fill[i], 1'b0, 1'b0);
    check_eq("t3_full", full, 1'b1);
    cycle("t3_ovf", 1'b1, 8'h55, 1'b0, 1'b0);
    check_eq("t3_ovf_set", overflow, 1'b1);
`ifdef OUTPORT_DROP_OLDEST_EN
    check_eq("t3_latched", out_latched, 8'h55);
    check_eq("t3_head", bus.out_data, 8'h22);
`else
    check_eq("t3_latched", out_latched, 8'h44);
    check_eq("t3_head", bus.out_data, 8'h11);
`endif

    // 5: clear overflow, then clear collides with an overflowing write
    cycle("t5_clr", 1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_cleared", overflow, 1'b0);
    cycle("t5_setwins", 1'b1, 8'h99, 1'b0, 1'b1);
    check_eq("t5_set_prio", overflow, 1'b1);
    for (int i = 0; i < 4; i++) cycle("t3_drain", 1'b0, '0, 1'b1, 1'b0);
    cycle("t5_clr2", 1'b0, '0, 1'b0, 1'b1);

    // 4: full FIFO, write and read in the same cycle
    for (int i = 0; i < 4; i++) cycle("t4_fill", 1'b1, fill[i], 1'b0, 1'b0);
    cycle("t4_both", 1'b1, 8'h66, 1'b1, 1'b0);
    check_eq("t4_count", count, 3'd4);
    check_eq("t4_no_ovf", overflow, 1'b0);
    check_eq("t4_head", bus.out_data, 8'h22);
    for (int i = 0; i < 4; i++) cycle("t4_drain", 1'b0, '0, 1'b1, 1'b0);

    // 6: async reset with three words queued
    for (int i = 0; i < 3; i++) cycle("t6_fill", 1'b1, fill[i], 1'b0, 1'b0);
    bus.load_out = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("t6_async");
    @(posedge clk);
    #1 reset = 1'b0;
    cycle("t6_after", 1'b1, 8'h77, 1'b0, 1'b0);
    check_eq("t6_data_77", bus.out_data, 8'h77);
    cycle("t6_read", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic, alternating between producer-heavy and consumer-heavy phases
    for (int i = 0; i < 800; i++) begin
      int ld_pct;
      int rd_pct;
      ld_pct = ((i / 100) % 2 == 0) ? 70 : 30;
      rd_pct = ((i / 100) % 2 == 0) ? 30 : 70;
      cycle("rand",
            $urandom_range(0, 99) < ld_pct,
            DW'($urandom),
            $urandom_range(0, 99) < rd_pct,
            $urandom_range(0, 99) < 8);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
